// File: rtl/alu_pkg.sv
// Shared ALU definitions: select-code type and constants used by the operand/result
// muxes and by the ALU opcode decode.
package alu_pkg;

    localparam int unsigned SEL_W     = 2;
    localparam int unsigned WIDTH_MIN = 1;
    localparam int unsigned WIDTH_MAX = 64;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_A = 2'b00;
    localparam sel_t SEL_B = 2'b01;
    localparam sel_t SEL_C = 2'b10;
    localparam sel_t SEL_D = 2'b11;

endpackage

// File: rtl/mux_4x1_core.sv
// Purely combinational WIDTH-bit 4:1 selector; every bit uses the same select.
module mux_4x1_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  sel_t             sel,
    output logic [WIDTH-1:0] y_c
);

    // All four codes are legal, so the default is only a latch guard.
    always_comb begin
        y_c = a;
        unique case (sel)
            SEL_A: y_c = a;
            SEL_B: y_c = b;
            SEL_C: y_c = c;
            SEL_D: y_c = d;
        endcase
    end

endmodule

// File: rtl/mux_4x1.sv
// Registered 4:1 mux with valid flag: captures the selected input one cycle after
// a request; y holds its value when no request is present.
module mux_4x1
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  sel_t             sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic             out_valid
);

    logic [WIDTH-1:0] sel_data_c;

    mux_4x1_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .sel (sel),
        .y_c (sel_data_c)
    );

    // Reset wins over a same-cycle request, discarding it.
    always_ff @(posedge clk) begin
        if (rst) begin
            y         <= WIDTH'(0);
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y <= sel_data_c;
            end
        end
    end

endmodule

// File: tb/tb_mux_4x1.sv
// Bench for mux_4x1: 1-bit and 32-bit instances share stimulus (1-bit sees bit 0).
module tb_mux_4x1;

    typedef struct {
        string       name;
        logic        rst;
        logic        iv;
        logic [1:0]  sel;
        logic [31:0] a, b, c, d;
        logic [31:0] ey;
        logic        ev;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv;
    logic [1:0]  sel;
    logic [31:0] a, b, c, d;
    logic [31:0] y32;
    logic        y1;
    logic        v32, v1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_y = '0;
    logic        m_v = 1'b0;

    always #5 clk = ~clk;

    mux_4x1 #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
        .sel(sel), .in_valid(iv), .y(y32), .out_valid(v32)
    );

    mux_4x1 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]),
        .sel(sel), .in_valid(iv), .y(y1), .out_valid(v1)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(string name, logic r, logic v, logic [1:0] s,
                                logic [31:0] va, logic [31:0] vb, logic [31:0] vc,
                                logic [31:0] vd, logic [31:0] ey, logic ev);
        vec_t t;
        t.name = name; t.rst = r; t.iv = v; t.sel = s;
        t.a = va; t.b = vb; t.c = vc; t.d = vd; t.ey = ey; t.ev = ev;
        return t;
    endfunction

    // Drive one cycle, advance the reference model, sample 1 time unit after the edge.
    task automatic step(input logic r, input logic v, input logic [1:0] s,
                        input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] vc, input logic [31:0] vd);
        logic [31:0] ins [4];
        @(negedge clk);
        rst = r; iv = v; sel = s; a = va; b = vb; c = vc; d = vd;
        ins[0] = va; ins[1] = vb; ins[2] = vc; ins[3] = vd;
        @(posedge clk);
        if (r) begin
            m_y = '0;
            m_v = 1'b0;
        end else if (v) begin
            m_y = ins[s];
            m_v = 1'b1;
        end else begin
            m_v = 1'b0;
        end
        #1;
    endtask

    task automatic check_model(string name);
        check({name, ".y32"}, y32, m_y);
        check({name, ".v32"}, 32'(v32), 32'(m_v));
        check({name, ".y1"},  32'(y1), 32'(m_y[0]));
        check({name, ".v1"},  32'(v1), 32'(m_v));
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b1; iv = 1'b0; sel = 2'b00; a = '0; b = '0; c = '0; d = '0;

        // Reset with a pending request, then first idle cycle after reset.
        tbl.push_back(mk("rst0", 1, 1, 2'b00, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 0));
        tbl.push_back(mk("rst1", 1, 1, 2'b00, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 0));
        tbl.push_back(mk("post_rst", 0, 0, 2'b00, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 0));
        // Sweep pattern 1 and its inverse.
        tbl.push_back(mk("sw1_a", 0, 1, 2'b00, 32'h0, 32'h1, 32'h0, 32'h1, 32'h0, 1));
        tbl.push_back(mk("sw1_b", 0, 1, 2'b01, 32'h0, 32'h1, 32'h0, 32'h1, 32'h1, 1));
        tbl.push_back(mk("sw1_c", 0, 1, 2'b10, 32'h0, 32'h1, 32'h0, 32'h1, 32'h0, 1));
        tbl.push_back(mk("sw1_d", 0, 1, 2'b11, 32'h0, 32'h1, 32'h0, 32'h1, 32'h1, 1));
        tbl.push_back(mk("sw2_a", 0, 1, 2'b00, 32'h1, 32'h0, 32'h1, 32'h0, 32'h1, 1));
        tbl.push_back(mk("sw2_b", 0, 1, 2'b01, 32'h1, 32'h0, 32'h1, 32'h0, 32'h0, 1));
        tbl.push_back(mk("sw2_c", 0, 1, 2'b10, 32'h1, 32'h0, 32'h1, 32'h0, 32'h1, 1));
        tbl.push_back(mk("sw2_d", 0, 1, 2'b11, 32'h1, 32'h0, 32'h1, 32'h0, 32'h0, 1));
        // Capture b, then hold while sel and data toggle.
        tbl.push_back(mk("hold_cap", 0, 1, 2'b01, 32'h0, 32'h1, 32'h0, 32'h0, 32'h1, 1));
        tbl.push_back(mk("hold1", 0, 0, 2'b00, 32'hFFFF_FFFE, 32'h0, 32'h0, 32'h0, 32'h1, 0));
        tbl.push_back(mk("hold2", 0, 0, 2'b10, 32'h1, 32'h0, 32'h0, 32'hA, 32'h1, 0));
        tbl.push_back(mk("hold3", 0, 0, 2'b11, 32'h0, 32'h0, 32'h5, 32'h0, 32'h1, 0));
        // Wide values, no bit mixing between inputs.
        tbl.push_back(mk("wide_a", 0, 1, 2'b00, 32'h0000_0001, 32'hDEAD_BEEF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 1));
        tbl.push_back(mk("wide_b", 0, 1, 2'b01, 32'h0000_0001, 32'hDEAD_BEEF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1));
        tbl.push_back(mk("wide_c", 0, 1, 2'b10, 32'h0000_0001, 32'hDEAD_BEEF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1));
        tbl.push_back(mk("wide_d", 0, 1, 2'b11, 32'h0000_0001, 32'hDEAD_BEEF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1));
        // Request coinciding with reset is discarded; next request is normal.
        tbl.push_back(mk("mid_rst", 1, 1, 2'b11, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0, 0));
        tbl.push_back(mk("after_rst", 0, 1, 2'b11, 32'h0, 32'h0, 32'h0, 32'h1234_5679, 32'h1234_5679, 1));
        tbl.push_back(mk("idle", 0, 0, 2'b00, 32'h7, 32'h7, 32'h7, 32'h7, 32'h1234_5679, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].iv, tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d);
            check({tbl[i].name, ".y32"}, y32, tbl[i].ey);
            check({tbl[i].name, ".v32"}, 32'(v32), 32'(tbl[i].ev));
            check({tbl[i].name, ".y1"},  32'(y1), 32'(tbl[i].ey[0]));
            check({tbl[i].name, ".v1"},  32'(v1), 32'(tbl[i].ev));
        end

        // Hand sequence: reset while idle clears a held value; back-to-back captures.
        step(0, 1, 2'b10, 32'h0, 32'h0, 32'hCAFE_F00D, 32'h0);
        check_model("seq_cap");
        step(1, 0, 2'b10, 32'h0, 32'h0, 32'hCAFE_F00D, 32'h0);
        check_model("seq_rst_idle");
        step(0, 1, 2'b00, 32'h3, 32'h0, 32'h0, 32'h0);
        check_model("seq_b2b0");
        step(0, 1, 2'b01, 32'h3, 32'h6, 32'h0, 32'h0);
        check_model("seq_b2b1");

        // Randomised traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom);
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
